// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state type and parameter defaults for the framebuffer swap controller
package fb_pkg;

  typedef enum logic [1:0] {
    WRITE = 2'd0,
    PEND  = 2'd1,
    GUARD = 2'd2
  } fb_swap_state_t;

  localparam int GUARD_CYCLES_DEF = 4;
  localparam int STAT_W_DEF       = 16;

endpackage

// File: rtl/fb_sat_counter.sv
// rtl/fb_sat_counter.sv - saturating up-counter with synchronous clear
module fb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Increment on request, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register; clear takes priority over increment.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// rtl/fb_swap_ctrl.sv - double-buffer bank swap controller; FB_SWAP_STATS_EN enables swap/repeat counters
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int STAT_W       = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_done,
  input  logic              vblank,
  input  logic              wr_we,
  output logic              fb_we,
  output logic              wr_ready,
  output logic              selection,
  output logic              swap_done,
  output logic              err,
  output logic [STAT_W-1:0] swap_cnt,
  output logic [STAT_W-1:0] repeat_cnt
);

  // A zero guard still needs a legal (unused) one-bit counter.
  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GLOAD = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;

  fb_swap_state_t state_q, state_d;
  logic [GW-1:0]  gcnt_q, gcnt_d;
  logic           sel_q, sel_d;
  logic           swap_done_q;
  logic           err_q, err_d;
  logic           swap_evt;

  // Next-state logic: a swap happens only on vblank with a completed frame.
  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    swap_evt = 1'b0;
    unique case (state_q)
      WRITE: begin
        if (frame_done && vblank) begin
          swap_evt = 1'b1;
        end else if (frame_done) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (vblank) begin
          swap_evt = 1'b1;
        end
      end
      GUARD: begin
        if (gcnt_q == '0) begin
          state_d = WRITE;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: state_d = WRITE;
    endcase
    if (swap_evt) begin
      state_d = (GUARD_CYCLES > 0) ? GUARD : WRITE;
      gcnt_d  = GLOAD;
    end
    sel_d = sel_q ^ swap_evt;
    // frame_done outside WRITE is dropped but latched as an error.
    err_d = err_q | (frame_done && (state_q != WRITE));
  end

  // State, bank select, swap pulse and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WRITE;
      gcnt_q      <= '0;
      sel_q       <= 1'b0;
      swap_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      sel_q       <= sel_d;
      swap_done_q <= swap_evt;
      err_q       <= err_d;
    end
  end

  assign wr_ready  = (state_q == WRITE);
  assign fb_we     = wr_we & wr_ready;
  assign selection = sel_q;
  assign swap_done = swap_done_q;
  assign err       = err_q;

`ifdef FB_SWAP_STATS_EN
  logic rep_evt;

  // A vblank that brings no new frame repeats the displayed one.
  assign rep_evt = vblank && (((state_q == WRITE) && !frame_done) || (state_q == GUARD));

  fb_sat_counter #(.W(STAT_W)) u_swap_cnt (
    .clk (clk),
    .clr (rst),
    .inc (swap_evt),
    .cnt (swap_cnt)
  );

  fb_sat_counter #(.W(STAT_W)) u_repeat_cnt (
    .clk (clk),
    .clr (rst),
    .inc (rep_evt),
    .cnt (repeat_cnt)
  );
`else
  assign swap_cnt   = '0;
  assign repeat_cnt = '0;
`endif

endmodule

// File: doc/fb_swap_ctrl.md
# fb_swap_ctrl

Double-buffer swap controller for the two-bank framebuffer. Owns the bank-select signal, accepts "frame complete" from the pixel writer, and flips banks only at the display's vertical-blank boundary so scanout never shows a torn frame. Gates the writer's write enable so a completed back frame is never overwritten before it is shown. Sits in the display clock domain between the writer front-end and the framebuffer's `selection`/`we` inputs.

## Interface

- `GUARD_CYCLES`, 4: cycles after a swap during which writes stay blocked, so in-flight scanout reads drain; 0 means no guard period.
- `STAT_W`, 16: width of the statistics counters.

- `clk`  in  1  display/system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `frame_done`  in  1  single-cycle pulse from the writer: back bank holds a complete frame.
- `vblank`  in  1  single-cycle pulse from scanout at the start of vertical blank.
- `wr_we`  in  1  raw writer write enable.
- `fb_we`  out  1  gated write enable to the framebuffer, equal to `wr_we & wr_ready`.
- `wr_ready`  out  1  writer may write the back bank.
- `selection`  out  1  bank select. 1: bank 1 displayed, bank 2 written. 0: bank 2 displayed, bank 1 written.
- `swap_done`  out  1  single-cycle pulse on the cycle `selection` changes.
- `err`  out  1  sticky flag: `frame_done` arrived while not in WRITE.
- `swap_cnt`  out  STAT_W  number of swaps performed.
- `repeat_cnt`  out  STAT_W  number of vblanks that passed with no new frame (old frame shown again).

## Operation

- States:
  - WRITE: writer active.
  - PEND: frame complete, waiting for vblank.
  - GUARD: post-swap drain.
- Transitions:
  - WRITE, `frame_done` and no `vblank` → PEND.
  - WRITE, `frame_done` and `vblank` in the same cycle → swap immediately, then GUARD (or WRITE if `GUARD_CYCLES`=0).
  - WRITE, `vblank` only → stay in WRITE; increment `repeat_cnt`.
  - PEND, `vblank` → toggle `selection`, pulse `swap_done`, increment `swap_cnt`, load the guard counter with `GUARD_CYCLES`-1, enter GUARD (or WRITE if 0).
  - PEND, no `vblank` → stay in PEND.
  - GUARD: decrement the counter each cycle; at 0 → WRITE.
- `wr_ready` = (state == WRITE). It is decoded combinationally from the state register.
- `frame_done` in PEND or GUARD is ignored, sets `err`, and does not queue a swap.
- `vblank` in GUARD increments `repeat_cnt` (the frame just swapped in is repeated).
- Counters saturate at all-ones and never wrap.
- Reset mid-operation: returns to WRITE. Any pending swap is discarded. `selection` returns to 0.

## Timing

- Reset values:
  - state = WRITE
  - `selection` = 0
  - `swap_done` = 0
  - `err` = 0
  - `swap_cnt` = 0 and `repeat_cnt` = 0
  - therefore `wr_ready` = 1
- `frame_done` sampled at edge N:
  - `wr_ready` is low from cycle N+1.
  - A `wr_we` write in cycle N itself still passes, as the final pixel.
- Swap latency:
  - `vblank` sampled in PEND at edge N → `selection` toggles and `swap_done` is high in cycle N+1.
  - `swap_done` is high for exactly one cycle.
- With `GUARD_CYCLES`=G>0, `wr_ready` returns high in cycle N+1+G.
- With `GUARD_CYCLES`=0, `wr_ready` returns high in cycle N+1.
- `fb_we` is combinational, with zero added latency relative to `wr_we`.

## Configuration

- `FB_SWAP_STATS_EN`
  - Defined: `swap_cnt` and `repeat_cnt` are implemented as saturating STAT_W counters.
  - Undefined: both ports remain present and are tied to 0; no counter logic is built.
- `err` and all swap behaviour are identical either way.

## Structure

- Package `fb_pkg` holds:
  - state enum `fb_swap_state_t` (WRITE, PEND, GUARD);
  - localparam defaults for `GUARD_CYCLES` and `STAT_W`.
- Sub-module `fb_sat_counter` (saturating increment, synchronous clear) is instantiated twice, only when `FB_SWAP_STATS_EN` is defined.
- The guard counter is width $clog2(GUARD_CYCLES+1) and stays inline.

## Test plan

- Reset, then idle 10 cycles → `selection`=0, `wr_ready`=1, `err`=0, both counters 0.
- Pulse `frame_done` at cycle 5 and `vblank` at cycle 20, with G=4:
  - `wr_ready` low from cycle 6;
  - `selection`=1 and `swap_done` high in cycle 21 only;
  - `wr_ready` high again at cycle 25;
  - `swap_cnt`=1.
- `frame_done` and `vblank` in the same cycle while in WRITE → swap in the next cycle, `swap_cnt` increments, `repeat_cnt` unchanged.
- Three `vblank` pulses with no `frame_done` → `repeat_cnt`=3 and `selection` unchanged. Then a second `frame_done` during PEND → `err`=1 (sticky), exactly one swap occurs.
- `wr_we` held high throughout → `fb_we` is high only while `wr_ready`=1, including the `frame_done` cycle.
- Assert `rst` during PEND → next cycle state is WRITE, `selection`=0. A later `vblank` causes no swap. With the macro undefined, counters read 0 across all scenarios.
